// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter that shares one block memory between the
// instruction cache (port 0) and the data cache (port 1).
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_read,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_writedata,
  output logic [DATA_WIDTH-1:0] p0_readdata,
  output logic                  p0_busywait,
  input  logic                  p1_read,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_writedata,
  output logic [DATA_WIDTH-1:0] p1_readdata,
  output logic                  p1_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait,
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic {StIdle, StServe} state_e;

  state_e                state_q, state_d;
  logic [1:0]            req, elig;
  logic [1:0]            done_q, done_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  sel_read, sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign req  = {p1_read | p1_write, p0_read | p0_write};
  // A request that completed last cycle is still up during its done pulse; keep it out.
  assign elig = req & ~done_q;

  assign p0_busywait = req[0] & ~done_q[0];
  assign p1_busywait = req[1] & ~done_q[1];
  assign p0_readdata = rdata0_q;
  assign p1_readdata = rdata1_q;
  assign grant_id    = grant_q;

  always_comb begin
    sel_read  = grant_q ? p1_read      : p0_read;
    sel_write = grant_q ? p1_write     : p0_write;
    sel_addr  = grant_q ? p1_address   : p0_address;
    sel_wdata = grant_q ? p1_writedata : p0_writedata;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    done_d        = 2'b00;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    busy          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (elig != 2'b00) begin
          state_d = StServe;
          grant_d = (elig == 2'b11) ? ~last_q : elig[1];
          last_d  = grant_d;
        end
      end
      StServe: begin
        busy          = 1'b1;
        mem_read      = sel_read & ~sel_write;
        mem_write     = sel_write;
        mem_address   = sel_addr;
        mem_writedata = sel_wdata;
        if (!mem_busywait) begin
          state_d         = StIdle;
          done_d[grant_q] = 1'b1;
          if (sel_read && !sel_write) begin
            if (grant_q) rdata1_d = mem_readdata;
            else         rdata0_d = mem_readdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, reference
// memory image, directed vector table, corner sequences and random traffic.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clock = 1'b0;
  logic reset;
  logic [1:0]         rd, wr, bw;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata, rdata;
  logic               mem_read, mem_write, mem_busywait, grant_id, busy;
  logic [AW-1:0]      mem_address;
  logic [DW-1:0]      mem_writedata, mem_readdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .p0_read(rd[0]), .p0_write(wr[0]), .p0_address(addr[0]), .p0_writedata(wdata[0]),
    .p0_readdata(rdata[0]), .p0_busywait(bw[0]),
    .p1_read(rd[1]), .p1_write(wr[1]), .p1_address(addr[1]), .p1_writedata(wdata[1]),
    .p1_readdata(rdata[1]), .p1_busywait(bw[1]),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .grant_id(grant_id), .busy(busy)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Initial memory image; address 0x10 holds the reference pattern.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    if (a == 28'h10) return 128'h00112233445566778899AABBCCDDEEFF;
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  // Behavioural memory: stalls cur_lat cycles per transaction, then completes.
  int unsigned   cnt;
  int unsigned   dir_lat = 0;
  int unsigned   rnd_lat = 0;
  int unsigned   cur_lat;
  bit            rand_mode = 1'b0;
  logic [DW-1:0] mem_store [256];
  bit            mem_valid [256];

  assign cur_lat      = rand_mode ? rnd_lat : dir_lat;
  assign mem_busywait = !((mem_read || mem_write) && cnt >= cur_lat);

  always_comb begin
    mem_readdata = mem_valid[mem_address[7:0]] ? mem_store[mem_address[7:0]] : dflt(mem_address);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 0;
    end else if (mem_read || mem_write) begin
      if (!mem_busywait) begin
        cnt <= 0;
        if (mem_write) begin
          mem_store[mem_address[7:0]] <= mem_writedata;
          mem_valid[mem_address[7:0]] <= 1'b1;
        end
        rnd_lat <= $urandom_range(0, 4);
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // Reference image of memory as the requesters expect it to be.
  logic [DW-1:0]      ref_store [256];
  bit                 ref_valid [256];
  logic [1:0][DW-1:0] last_rd;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_valid[a[7:0]] ? ref_store[a[7:0]] : dflt(a);
  endfunction

  task automatic apply(input bit p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    rd[p] = r; wr[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic finish_txn(input bit p);
    if (wr[p]) begin
      ref_store[addr[p][7:0]] = wdata[p];
      ref_valid[addr[p][7:0]] = 1'b1;
    end else if (rd[p]) begin
      last_rd[p] = ref_rd(addr[p]);
    end
    checkw(p ? "p1_readdata" : "p0_readdata", rdata[p], last_rd[p]);
  endtask

  task automatic wait_done(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!bw[p]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout: port %0d busywait still 1, required 0 within 300 cycles", p);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rd = '0;
  endtask

  // Single transaction with the other port idle.
  task automatic do_txn(input bit p, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int unsigned lat,
                        input logic exp_mr, input logic exp_mw);
    int unsigned stall;
    bit          o;
    bit          ok;
    o = ~p;
    stall = 0;
    ok = 1'b0;
    dir_lat = lat;
    @(negedge clock);
    apply(p, r, w, a, d);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check1("first_cycle_busy", busy, 1'b1);
        check1("grant_id", grant_id, p);
        check1("mem_read", mem_read, exp_mr);
        check1("mem_write", mem_write, exp_mw);
        checkw("mem_address", DW'(mem_address), DW'(a));
        if (w) checkw("mem_writedata", mem_writedata, d);
      end
      if (bw[p]) stall++;
      else begin ok = 1'b1; break; end
    end
    checkw("stall_cycles", DW'(stall), DW'(lat + 1));
    if (ok) finish_txn(p);
    check1("other_busywait", bw[o], 1'b0);
    checkw("other_readdata", rdata[o], last_rd[o]);
    apply(p, 1'b0, 1'b0, '0, '0);
  endtask

  bit          gq [$];
  int unsigned gs [$];
  int unsigned dc0 [$];

  // Both ports read and re-request until each has completed 'quota' transactions.
  task automatic both_ports(input int unsigned quota, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1);
    int unsigned n_done [2];
    bit          pb;
    int unsigned cyc;
    n_done[0] = 0;
    n_done[1] = 0;
    gq.delete(); gs.delete(); dc0.delete();
    @(negedge clock);
    apply(1'b0, 1'b1, 1'b0, a0, '0);
    apply(1'b1, 1'b1, 1'b0, a1, '0);
    pb = 1'b0;
    for (cyc = 0; cyc < 400 && (n_done[0] < quota || n_done[1] < quota); cyc++) begin
      @(negedge clock);
      if (busy && !pb) begin gq.push_back(grant_id); gs.push_back(cyc); end
      pb = busy;
      for (int q = 0; q < 2; q++) begin
        bit pp;
        pp = q[0];
        if (rd[pp] && !bw[pp]) begin
          finish_txn(pp);
          n_done[q]++;
          if (!pp) dc0.push_back(cyc);
          if (n_done[q] == quota) apply(pp, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    if (n_done[0] < quota || n_done[1] < quota) begin
      n_checks++;
      $display("FAIL both_ports timeout: done %0d/%0d required %0d each", n_done[0], n_done[1],
               quota);
    end
  endtask

  task automatic requester(input bit p, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      int unsigned gap, kind;
      gap = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      if (gap != 0) begin
        apply(p, 1'b0, 1'b0, '0, '0);
        repeat (gap) @(negedge clock);
      end
      apply(p, kind < 2, kind >= 2 && kind[0] == 1'b0 ? 1'b1 : kind == 3,
            AW'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
      wait_done(p, ok);
      if (ok) finish_txn(p);
    end
    apply(p, 1'b0, 1'b0, '0, '0);
  endtask

  // Protocol monitor: memory side follows the owner, the other port stalls, no starvation.
  int         starve [2];
  bit         prev_busy = 1'b0;
  logic [1:0] prev_req = 2'b00;

  initial begin
    starve[0] = 0;
    starve[1] = 0;
    forever begin
      @(negedge clock);
      #1;
      if (busy) begin
        bit g;
        g = grant_id;
        check1("mon_read", mem_read, rd[g] & ~wr[g]);
        check1("mon_write", mem_write, wr[g]);
        checkw("mon_address", DW'(mem_address), DW'(addr[g]));
        checkw("mon_writedata", mem_writedata, wdata[g]);
        check1("mon_owner_stall", bw[g], 1'b1);
        check1("mon_other_stall", bw[!g], rd[!g] | wr[!g]);
        if (!prev_busy) begin
          if (prev_req[!g]) starve[!g]++;
          starve[g] = 0;
          check1("mon_no_starve", starve[!g] > 1, 1'b0);
        end
      end
      prev_busy = busy;
      prev_req  = rd | wr;
    end
  end

  typedef struct {
    bit          port;
    logic        r, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned lat;
    logic        exp_mr, exp_mw;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit ok;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0, 15, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 28'h00000A0, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 3,
               1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 28'h0000020, 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0, 2,
               1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 28'h00000A0, 128'h0, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 28'h0000020, 128'h0, 1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 28'h0000033, 128'h0, 4, 1'b1, 1'b0};

    reset = 1'b1;
    rd = '0; wr = '0; addr = '0; wdata = '0; last_rd = '0;
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_mem_read", mem_read, 1'b0);
    check1("rst_mem_write", mem_write, 1'b0);
    check1("rst_grant_id", grant_id, 1'b0);
    check1("rst_p0_busywait", bw[0], 1'b0);
    check1("rst_p1_busywait", bw[1], 1'b0);
    checkw("rst_p0_readdata", rdata[0], '0);
    checkw("rst_p1_readdata", rdata[1], '0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i].port, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat,
             tbl[i].exp_mr, tbl[i].exp_mw);
      if (i == 0) checkw("pattern_read", rdata[0], 128'h00112233445566778899AABBCCDDEEFF);
    end

    // Holding the request past the done pulse must stall again, not complete twice.
    dir_lat = 2;
    @(negedge clock);
    apply(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
    wait_done(1'b0, ok);
    if (ok) finish_txn(1'b0);
    @(negedge clock);
    check1("done_one_cycle", bw[0], 1'b1);
    wait_done(1'b0, ok);
    if (ok) finish_txn(1'b0);
    apply(1'b0, 1'b0, 1'b0, '0, '0);

    // Simultaneous reads after reset: port 0 first, port 1 right after its done pulse.
    do_reset();
    dir_lat = 3;
    both_ports(1, 28'h0000040, 28'h0000050);
    checkw("tie_grant_count", DW'(gq.size()), DW'(2));
    if (gq.size() == 2 && dc0.size() == 1) begin
      check1("tie_first_grant", gq[0], 1'b0);
      check1("tie_second_grant", gq[1], 1'b1);
      checkw("tie_second_start", DW'(gs[1]), DW'(dc0[0] + 1));
    end

    // Continuous back-to-back traffic alternates ownership.
    dir_lat = 1;
    both_ports(2, 28'h0000070, 28'h0000071);
    checkw("b2b_grant_count", DW'(gq.size()), DW'(4));
    if (gq.size() == 4) begin
      for (int i = 0; i < 4; i++) check1("b2b_grant", gq[i], i[0]);
    end

    // Asynchronous reset five cycles into a port 1 read.
    dir_lat = 20;
    @(negedge clock);
    apply(1'b1, 1'b1, 1'b0, 28'h0000060, '0);
    repeat (5) @(negedge clock);
    check1("pre_reset_mem_read", mem_read, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("async_mem_read", mem_read, 1'b0);
    check1("async_busy", busy, 1'b0);
    checkw("async_p1_readdata", rdata[1], '0);
    checkw("async_p0_readdata", rdata[0], '0);
    @(negedge clock);
    reset = 1'b0;
    last_rd = '0;
    apply(1'b1, 1'b0, 1'b0, '0, '0);
    do_txn(1'b1, 1'b1, 1'b0, 28'h0000060, '0, 2, 1'b1, 1'b0);

    // Random concurrent traffic with random memory latency.
    do_reset();
    rand_mode = 1'b1;
    fork
      requester(1'b0, 25);
      requester(1'b1, 25);
    join
    rand_mode = 1'b0;
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single block-wide main data memory between the instruction cache (port 0) and the data cache (port 1).
- Uses the same read/write/busywait block handshake on both sides, so each cache sees a private memory and the memory sees one master.
- Round-robin grant with transaction lock: a grant holds until memory completes.
- Read data is registered per port.

Parameters:
- ADDR_WIDTH, 28, block address width (16-byte blocks).
- DATA_WIDTH, 128, block data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_read  in  1  port 0 block read request.
- p0_write  in  1  port 0 block write request.
- p0_address  in  ADDR_WIDTH  port 0 block address.
- p0_writedata  in  DATA_WIDTH  port 0 write block.
- p0_readdata  out  DATA_WIDTH  port 0 read block, registered.
- p0_busywait  out  1  port 0 stall.
- p1_read, p1_write, p1_address, p1_writedata, p1_readdata, p1_busywait: same as port 0, for port 1.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_address  out  ADDR_WIDTH  memory block address.
- mem_writedata  out  DATA_WIDTH  memory write block.
- mem_readdata  in  DATA_WIDTH  memory read block.
- mem_busywait  in  1  memory stall.
- grant_id  out  1  port currently owning memory; valid when busy is high.
- busy  out  1  a memory transaction is in flight.

Behaviour:
- Requester contract:
  - A port holds read/write, address and writedata stable from assertion until the cycle its busywait is low.
  - Read and write both high on one port counts as a write.
- Port request: req_n = pN_read | pN_write.
- Port stall: pN_busywait = req_n & ~done_n (combinational). done_n is a registered one-cycle completion pulse.
- States: IDLE, SERVE.
- IDLE:
  - Mem outputs: mem_read = mem_write = 0; mem_address and mem_writedata are don't-care, driven 0.
  - Eligible port: req_n & ~done_n. This blocks re-granting a request completed in the previous cycle.
  - One eligible port: grant it.
  - Both eligible: grant the port not equal to last_grant.
  - On grant, at the rising edge: state <= SERVE; grant_id <= n; last_grant <= n.
- SERVE:
  - Mem outputs are driven combinationally from the granted port: address, writedata, read = pN_read & ~pN_write, write = pN_write.
  - busy = 1.
  - At a rising edge where mem_busywait = 0:
    - On a read, pN_readdata <= mem_readdata.
    - done_n <= 1; state <= IDLE.
  - The other port's busywait stays high throughout.
- done_n clears at the next edge, so it is high for exactly one cycle.
- Latency: request at edge k means grant at edge k+1 and memory sees the request in cycle k+1. Total port stall = memory latency + 1 cycle arbitration + 1 completion cycle.
- Granted port drops its request in SERVE (protocol violation):
  - mem_read and mem_write fall to 0 and the memory counter stalls.
  - The arbiter stays in SERVE until mem_busywait = 0. No hang is required to be detected.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; done_0 = done_1 = 0; grant_id = 0; last_grant = 1 (port 0 wins the first tie).
  - p0_readdata = p1_readdata = 0; mem_read = mem_write = 0; busy = 0.
- pN_readdata holds its last value between reads; writes do not modify it.
- No combinational path from mem_readdata to pN_readdata.

Test Plan:
- Port 0 read only, address 0x0000010, memory returns 0x00112233445566778899AABBCCDDEEFF after 15 busy cycles:
  - mem_read high from the cycle after the request; p0_readdata equals the pattern.
  - p0_busywait low for exactly one cycle; p1 untouched.
- Both ports read in the same cycle after reset:
  - Port 0 is served first; port 1 is granted in the cycle after port 0's done pulse.
  - grant_id sequence 0 then 1; p1_busywait high throughout port 0's transaction.
- Both ports issue continuous back-to-back requests for 4 transactions:
  - grant_id alternates 0,1,0,1.
  - No port receives two consecutive grants while the other is waiting.
- Port 1 write of 0xDEADBEEF_CAFEBABE_01234567_89ABCDEF to address 0x00000A0:
  - mem_write = 1, mem_address = 0x00000A0, mem_writedata matches.
  - p1_readdata unchanged; done pulse one cycle.
- Port 0 asserts read and write together: the memory sees mem_write = 1 and mem_read = 0.
- Reset asserted mid-SERVE, 5 cycles into a port 1 read:
  - mem_read drops immediately (asynchronously); busy = 0; readdata = 0.
  - After release, a port 1 read completes normally.
